// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback
// and drives ALU-control selectors plus all datapath strobes. Memory waits are bounded by a timeout.
module multicycle_control_fsm #(
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       func7_mask,
    output logic       pc_source,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       illegal_instr,
    output logic       mem_timeout
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_RESET_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH
    } state_t;

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 wait_st;
    logic                 timeout;
    logic                 legal_op;

    assign wait_st  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // A ready on the timeout cycle completes normally; only a missing ready aborts.
    assign timeout  = wait_st && !mem_ready && (cnt_q == TMO);
    assign legal_op = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LW) ||
                      (opcode == OP_SW) || (opcode == OP_BEQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET_IDLE: state_d = S_FETCH;
            S_FETCH:      if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR:   state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:     if (mem_ready) state_d = S_WB_MEM;
                          else if (timeout) state_d = S_FETCH;
            S_MEM_WR:     if (mem_ready || timeout) state_d = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
            default:      state_d = S_RESET_IDLE;
        endcase
    end

    // Timeout in FETCH re-enters FETCH, so it must clear the counter explicitly.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || timeout)
            cnt_d = '0;
        else if (wait_st && !mem_ready && (cnt_q != TMO))
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        func7_mask    = 1'b0;
        pc_source     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_instr = 1'b0;
        mem_timeout   = timeout;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a     = 2'b10;
                alu_src_b     = 2'b10;
                illegal_instr = !legal_op;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = 2'b10;
                func7_mask = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_WB_ALU: reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                pc_source = 1'b1;
                pc_write  = zero;
            end
            default: ;
        endcase
    end

endmodule
